// File: rtl/e_mdu_pkg.sv
// Shared encodings and default latencies for the execute-stage multiply/divide unit.
package e_mdu_pkg;

  // MDOp command encodings; 101-111 decode as no operation.
  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULTU = 3'b001,
    MD_MULT  = 3'b010,
    MD_DIVU  = 3'b011,
    MD_DIV   = 3'b100
  } md_op_e;

  // MDAddrOp: which of HI/LO is the target of mt* and the source of mf*.
  localparam logic MD_SEL_LO = 1'b0;
  localparam logic MD_SEL_HI = 1'b1;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // True for the four commands that start a multi-cycle operation.
  function automatic logic md_is_op(input logic [2:0] op);
    return (op == MD_MULTU) || (op == MD_MULT) || (op == MD_DIVU) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers, pending results and
// a busy counter that models multi-cycle mult/div latency.
//
// Handshake: start is the accept strobe for an MD command. A command is
// taken only when the unit is idle (!busy) and not flushed (!req, !reset);
// any command presented while busy or flushed is dropped, never queued.
// The hazard unit is expected to hold MD-class instructions while
// start||busy, so nothing is lost in normal operation.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  MDOp,
  input  logic        MDWE,
  input  logic        MDAddrOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   phi, plo;
  logic          pzero;     // pending divide had B==0: skip the HI/LO commit

  logic          is_op;
  logic [63:0]   prod_u, prod_s;
  logic [31:0]   abs_a, abs_b, div_u, div_s;
  logic [31:0]   quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;
  logic [31:0]   nphi, nplo;
  logic          nzero;
  logic [CW-1:0] nlat;

  assign is_op = md_is_op(MDOp);
  assign start = is_op && !busy && !req && !reset;
  assign MDOut = (MDAddrOp == MD_SEL_HI) ? HI : LO;

  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

  // Signed divide on magnitudes; this also makes 0x80000000 / -1 come out
  // as 0x80000000 rem 0 without relying on overflow behaviour.
  assign abs_a = A[31] ? (~A + 32'd1) : A;
  assign abs_b = B[31] ? (~B + 32'd1) : B;
  // Divisors forced nonzero so a divide-by-zero never produces X; its
  // result is discarded anyway.
  assign div_u = (B == 32'd0) ? 32'd1 : B;
  assign div_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign quo_u = A / div_u;
  assign rem_u = A % div_u;
  assign quo_m = abs_a / div_s;
  assign rem_m = abs_a % div_s;
  assign quo_s = (A[31] ^ B[31]) ? (~quo_m + 32'd1) : quo_m;
  assign rem_s = A[31] ? (~rem_m + 32'd1) : rem_m;

  // Select the pending result and latency for the command on the inputs.
  always_comb begin
    nphi  = 32'd0;
    nplo  = 32'd0;
    nzero = 1'b0;
    nlat  = CW'(DIV_CYCLES);
    case (MDOp)
      MD_MULTU: begin nphi = prod_u[63:32]; nplo = prod_u[31:0]; nlat = CW'(MULT_CYCLES); end
      MD_MULT:  begin nphi = prod_s[63:32]; nplo = prod_s[31:0]; nlat = CW'(MULT_CYCLES); end
      MD_DIVU:  begin nphi = rem_u; nplo = quo_u; nzero = (B == 32'd0); end
      MD_DIV:   begin nphi = rem_s; nplo = quo_s; nzero = (B == 32'd0); end
      default:  ;
    endcase
  end

  // Accept, count down and commit operations; handle mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI    <= 32'd0;
      LO    <= 32'd0;
      busy  <= 1'b0;
      cnt   <= '0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      pzero <= 1'b0;
    end else if (start) begin
      phi   <= nphi;
      plo   <= nplo;
      pzero <= nzero;
      cnt   <= nlat;
      busy  <= 1'b1;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (!pzero) begin
          HI <= phi;
          LO <= plo;
        end
      end
    end else if (MDWE && !req && !is_op) begin
      if (MDAddrOp == MD_SEL_HI) HI <= A;
      else                       LO <= A;
    end
  end

endmodule
